cmd_issue_scheduler: RTL and testbench

CMD_ISSUE_SCHEDULER -- requirements
Module: cmd_issue_scheduler

---
 rtl/mchan_sched_pkg.sv | 17 +
 rtl/sched_rr_arbiter.sv | 30 +++
 rtl/cmd_issue_scheduler.sv | 171 +++++++++++++++++
 tb/tb_cmd_issue_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mchan_sched_pkg.sv
// Shared types and default sizing for the command issue scheduler.
package mchan_sched_pkg;

  localparam int unsigned DefNbCtrls      = 4;
  localparam int unsigned DefNbTransfers  = 8;
  localparam int unsigned DefSidWidth     = 3;
  localparam int unsigned DefCidWidth     = 2;
  localparam int unsigned DefCmdWidth     = 64;
  localparam int unsigned DefMaxOutstand  = 2;

  // IDLE: output slot empty; ISSUE: output slot holds a command awaiting out_gnt_i.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } sched_state_e;

endpackage

// File: rtl/sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i (wrapping) wins.
module sched_rr_arbiter #(
  parameter int unsigned NB_REQ = 4,
  parameter int unsigned IDX_W  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic [NB_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NB_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  // Scan requesters starting from the pointer; keep the first hit.
  always_comb begin
    logic [IDX_W-1:0] j;
    j       = '0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      j = IDX_W'((32'(ptr_i) + k) % NB_REQ);
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/cmd_issue_scheduler.sv
// Issues commands from several controllers to one downstream port, limiting
// each controller's in-flight commands and retiring them on per-SID terms.
module cmd_issue_scheduler
  import mchan_sched_pkg::*;
#(
  parameter int unsigned NB_CTRLS        = DefNbCtrls,
  parameter int unsigned NB_TRANSFERS    = DefNbTransfers,
  parameter int unsigned TRANS_SID_WIDTH = DefSidWidth,
  parameter int unsigned TRANS_CID_WIDTH = DefCidWidth,
  parameter int unsigned CMD_WIDTH       = DefCmdWidth,
  parameter int unsigned MAX_OUTSTANDING = DefMaxOutstand
) (
  input  logic                                              clk_i,
  input  logic                                              rst_ni,
  input  logic [NB_CTRLS-1:0]                               cmd_req_i,
  output logic [NB_CTRLS-1:0]                               cmd_gnt_o,
  input  logic [NB_CTRLS*CMD_WIDTH-1:0]                     cmd_data_i,
  input  logic [NB_CTRLS*TRANS_SID_WIDTH-1:0]               cmd_sid_i,
  output logic                                              out_req_o,
  input  logic                                              out_gnt_i,
  output logic [CMD_WIDTH-1:0]                              out_data_o,
  output logic [TRANS_SID_WIDTH-1:0]                        out_sid_o,
  output logic [TRANS_CID_WIDTH-1:0]                        out_cid_o,
  input  logic [NB_TRANSFERS-1:0]                           term_sig_i,
  output logic [NB_CTRLS*$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
  output logic                                              idle_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IdxW = (NB_CTRLS > 1) ? $clog2(NB_CTRLS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTSTANDING);

  sched_state_e state_q, state_d;
  logic [IdxW-1:0]            ptr_q, ptr_d;
  logic [CntW-1:0]            cnt_q [NB_CTRLS];
  logic [CntW-1:0]            cnt_d [NB_CTRLS];
  logic [NB_TRANSFERS-1:0]    valid_q, valid_d;
  logic [TRANS_CID_WIDTH-1:0] cid_q [NB_TRANSFERS];
  logic [TRANS_CID_WIDTH-1:0] cid_d [NB_TRANSFERS];
  logic [CMD_WIDTH-1:0]       data_q, data_d;
  logic [TRANS_SID_WIDTH-1:0] sid_q, sid_d;
  logic [TRANS_CID_WIDTH-1:0] ocid_q, ocid_d;

  logic [NB_CTRLS-1:0]        elig;
  logic [NB_CTRLS-1:0]        arb_gnt;
  logic [IdxW-1:0]            arb_idx;
  logic                       arb_valid;
  logic                       grant;
  logic [CMD_WIDTH-1:0]       arb_data;
  logic [TRANS_SID_WIDTH-1:0] arb_sid;
  logic [TRANS_CID_WIDTH-1:0] arb_cid;

  // Eligibility uses the registered count only, so a term never frees a slot in the same cycle.
  always_comb begin
    elig = '0;
    for (int unsigned c = 0; c < NB_CTRLS; c++) begin
      elig[c] = cmd_req_i[c] && (cnt_q[c] < CntMax);
    end
  end

  sched_rr_arbiter #(
    .NB_REQ (NB_CTRLS),
    .IDX_W  (IdxW)
  ) u_arb (
    .req_i   (elig),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign arb_data = cmd_data_i[32'(arb_idx)*CMD_WIDTH +: CMD_WIDTH];
  assign arb_sid  = cmd_sid_i[32'(arb_idx)*TRANS_SID_WIDTH +: TRANS_SID_WIDTH];
  assign arb_cid  = TRANS_CID_WIDTH'(arb_idx);

  // FSM: a new command is accepted when the slot is empty or being drained this cycle.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (out_gnt_i) begin
          if (arb_valid) grant   = 1'b1;
          else           state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output slot and round-robin pointer reload on every input grant.
  always_comb begin
    ptr_d  = ptr_q;
    data_d = data_q;
    sid_d  = sid_q;
    ocid_d = ocid_q;
    if (grant) begin
      ptr_d  = (arb_idx == IdxW'(NB_CTRLS - 1)) ? '0 : arb_idx + IdxW'(1);
      data_d = arb_data;
      sid_d  = arb_sid;
      ocid_d = arb_cid;
    end
  end

  // SID table and counters: retire terms against the old entries first, then record
  // the grant, so a term and a grant on the same SID leave the new entry valid.
  always_comb begin
    valid_d = valid_q;
    cid_d   = cid_q;
    cnt_d   = cnt_q;
    for (int unsigned s = 0; s < NB_TRANSFERS; s++) begin
      if (term_sig_i[s] && valid_q[s]) begin
        valid_d[s]        = 1'b0;
        cnt_d[cid_q[s]]   = cnt_d[cid_q[s]] - CntW'(1);
      end
    end
    if (grant) begin
      valid_d[arb_sid] = 1'b1;
      cid_d[arb_sid]   = arb_cid;
      cnt_d[arb_idx]   = cnt_d[arb_idx] + CntW'(1);
    end
  end

  // State registers with asynchronous active-low reset; reset drops any pending command.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '{default: '0};
      valid_q <= '0;
      cid_q   <= '{default: '0};
      data_q  <= '0;
      sid_q   <= '0;
      ocid_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      cid_q   <= cid_d;
      data_q  <= data_d;
      sid_q   <= sid_d;
      ocid_q  <= ocid_d;
    end
  end

  assign cmd_gnt_o  = grant ? arb_gnt : '0;
  assign out_req_o  = (state_q == ST_ISSUE);
  assign out_data_o = data_q;
  assign out_sid_o  = sid_q;
  assign out_cid_o  = ocid_q;

  // Pack per-controller counts and derive the idle indication.
  always_comb begin
    logic busy;
    busy          = 1'b0;
    outstanding_o = '0;
    for (int unsigned c = 0; c < NB_CTRLS; c++) begin
      outstanding_o[c*CntW +: CntW] = cnt_q[c];
      if (cnt_q[c] != '0) busy = 1'b1;
    end
    idle_o = (state_q == ST_IDLE) && !busy;
  end

endmodule

// File: tb/tb_cmd_issue_scheduler.sv
// Directed bench for cmd_issue_scheduler with a scoreboard of issued commands.
module tb_cmd_issue_scheduler;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic [3:0]   cmd_req;
  logic [3:0]   cmd_gnt;
  logic [255:0] cmd_data;
  logic [11:0]  cmd_sid;
  logic         out_req;
  logic         out_gnt;
  logic [63:0]  out_data;
  logic [2:0]   out_sid;
  logic [1:0]   out_cid;
  logic [7:0]   term;
  logic [7:0]   outstanding;
  logic         idle;

  typedef struct packed {
    logic [1:0]  cid;
    logic [2:0]  sid;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_n  = 0;
  logic [63:0] snap;

  always #5 clk = ~clk;

  cmd_issue_scheduler #(
    .NB_CTRLS        (4),
    .NB_TRANSFERS    (8),
    .TRANS_SID_WIDTH (3),
    .TRANS_CID_WIDTH (2),
    .CMD_WIDTH       (64),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .cmd_req_i     (cmd_req),
    .cmd_gnt_o     (cmd_gnt),
    .cmd_data_i    (cmd_data),
    .cmd_sid_i     (cmd_sid),
    .out_req_o     (out_req),
    .out_gnt_i     (out_gnt),
    .out_data_o    (out_data),
    .out_sid_o     (out_sid),
    .out_cid_o     (out_cid),
    .term_sig_i    (term),
    .outstanding_o (outstanding),
    .idle_o        (idle)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic refresh_data();
    for (int c = 0; c < 4; c++) cmd_data[c*64 +: 64] = {16'hA5A5, 16'(c), 32'(cyc_n)};
  endtask

  task automatic set_sid(input int c, input logic [2:0] s);
    cmd_sid[c*3 +: 3] = s;
  endtask

  // Expect controller c to be granted now; record what it must deliver downstream.
  task automatic exp_grant(input string tag, input int c);
    logic [3:0] g;
    exp_t e;
    g = 4'b0001 << c;
    chk(tag, 72'(cmd_gnt), 72'(g));
    e.cid  = 2'(c);
    e.sid  = cmd_sid[c*3 +: 3];
    e.data = cmd_data[c*64 +: 64];
    sb.push_back(e);
  endtask

  // Mid-cycle: score any downstream handshake, then advance to just after the next edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (out_req && out_gnt) begin
      chk("sb_nonempty", 72'(sb.size() != 0), 72'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_payload", 72'({out_cid, out_sid, out_data}), 72'({e.cid, e.sid, e.data}));
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
    refresh_data();
  endtask

  initial begin
    rst_ni  = 1'b0;
    cmd_req = '0;
    cmd_sid = '0;
    out_gnt = 1'b0;
    term    = '0;
    refresh_data();
    #3;
    chk("rst_gnt",   72'(cmd_gnt), 72'(0));
    chk("rst_req",   72'(out_req), 72'(0));
    chk("rst_idle",  72'(idle), 72'(1));
    chk("rst_outst", 72'(outstanding), 72'(0));
    chk("rst_data",  72'(out_data), 72'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    refresh_data();

    // All four requesting with a free downstream: c0..c3 back to back.
    cmd_req = 4'hF;
    out_gnt = 1'b1;
    set_sid(0, 3'd0); set_sid(1, 3'd1); set_sid(2, 3'd2); set_sid(3, 3'd3);
    #1;
    chk("A_req_idle", 72'(out_req), 72'(0));
    exp_grant("A_g0", 0);
    tick();
    for (int c = 1; c < 4; c++) begin
      #1;
      chk("A_req_cont", 72'(out_req), 72'(1));
      exp_grant("A_gn", c);
      tick();
    end
    cmd_req = '0;
    #1;
    chk("A_req_last", 72'(out_req), 72'(1));
    chk("A_nogrant",  72'(cmd_gnt), 72'(0));
    tick();
    #1;
    chk("A_drained", 72'(out_req), 72'(0));
    chk("A_outst",   72'(outstanding), 72'(8'h55));
    term = 8'h0F;
    tick();
    term = '0;
    #1;
    chk("A_retired", 72'(outstanding), 72'(0));
    chk("A_idle",    72'(idle), 72'(1));

    // c1 alone: two grants, held at the limit, third grant after a term.
    cmd_req = 4'b0010;
    set_sid(1, 3'd4);
    #1; exp_grant("B_g1", 1); tick();
    set_sid(1, 3'd6);
    #1; exp_grant("B_g2", 1); tick();
    #1;
    chk("B_hold",  72'(cmd_gnt), 72'(0));
    chk("B_cnt2",  72'(outstanding[3:2]), 72'(2));
    tick();
    term = 8'h10;
    #1;
    chk("B_nobypass", 72'(cmd_gnt), 72'(0));
    tick();
    term = '0;
    set_sid(1, 3'd4);
    #1;
    chk("B_cnt1", 72'(outstanding[3:2]), 72'(1));
    exp_grant("B_g3", 1);
    tick();
    cmd_req = '0;
    #1;
    chk("B_req3",  72'(out_req), 72'(1));
    chk("B_cnt2b", 72'(outstanding[3:2]), 72'(2));
    tick();
    term = 8'h50;
    tick();
    term = '0;
    #1;
    chk("B_clear", 72'(outstanding), 72'(0));

    // Downstream stalled for five cycles: payload frozen, no input grants.
    cmd_req = 4'b0100;
    out_gnt = 1'b0;
    set_sid(2, 3'd3);
    #1;
    exp_grant("C_g", 2);
    snap = cmd_data[2*64 +: 64];
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("C_gnt0",  72'(cmd_gnt), 72'(0));
      chk("C_req",   72'(out_req), 72'(1));
      chk("C_data",  72'(out_data), 72'(snap));
      chk("C_sid",   72'(out_sid), 72'(3));
      tick();
    end
    cmd_req = '0;
    out_gnt = 1'b1;
    tick();
    term = 8'h08;
    tick();
    term = '0;
    #1;
    chk("C_clear", 72'(outstanding), 72'(0));
    chk("C_req0",  72'(out_req), 72'(0));

    // c0 on SIDs 2 and 5: simultaneous terms, term+grant, term+grant on one SID.
    cmd_req = 4'b0001;
    set_sid(0, 3'd2);
    #1; exp_grant("D_g1", 0); tick();
    set_sid(0, 3'd5);
    #1; exp_grant("D_g2", 0); tick();
    set_sid(0, 3'd7);
    #1;
    chk("D_limit", 72'(cmd_gnt), 72'(0));
    chk("D_cnt2",  72'(outstanding[1:0]), 72'(2));
    tick();
    term = 8'h24;
    #1;
    chk("D_limit2", 72'(cmd_gnt), 72'(0));
    tick();
    term = '0;
    set_sid(0, 3'd2);
    #1;
    chk("D_multi_term", 72'(outstanding[1:0]), 72'(0));
    exp_grant("D_g3", 0);
    tick();
    set_sid(0, 3'd5);
    term = 8'h04;
    #1;
    chk("D_cnt1", 72'(outstanding[1:0]), 72'(1));
    exp_grant("D_g4", 0);
    tick();
    term = 8'h20;
    #1;
    chk("D_net_zero", 72'(outstanding[1:0]), 72'(1));
    exp_grant("D_g5", 0);
    tick();
    cmd_req = '0;
    term    = '0;
    #1;
    chk("D_same_sid", 72'(outstanding[1:0]), 72'(1));
    tick();
    term = 8'h20;
    #1;
    chk("D_cnt1b", 72'(outstanding[1:0]), 72'(1));
    chk("D_req0",  72'(out_req), 72'(0));
    tick();
    term = '0;
    #1;
    chk("D_sid_valid", 72'(outstanding), 72'(0));
    chk("D_idle",      72'(idle), 72'(1));

    // Term on an unused SID must not touch any counter.
    cmd_req = 4'b1000;
    set_sid(3, 3'd1);
    #1; exp_grant("E_g", 3); tick();
    cmd_req = '0;
    term    = 8'h80;
    #1;
    chk("E_gnt0", 72'(cmd_gnt), 72'(0));
    tick();
    term = '0;
    #1;
    chk("E_invalid_term", 72'(outstanding), 72'(8'h40));
    tick();

    // Reset while a command sits in the output slot.
    out_gnt = 1'b0;
    cmd_req = 4'b0001;
    set_sid(0, 3'd0);
    #1;
    chk("R_gnt", 72'(cmd_gnt), 72'(4'b0001));
    tick();
    cmd_req = '0;
    #1;
    chk("R_pending", 72'(out_req), 72'(1));
    #1;
    rst_ni = 1'b0;
    #1;
    chk("R_req0",  72'(out_req), 72'(0));
    chk("R_idle",  72'(idle), 72'(1));
    chk("R_outst", 72'(outstanding), 72'(0));
    chk("R_data",  72'(out_data), 72'(0));
    chk("R_gnt0",  72'(cmd_gnt), 72'(0));
    tick();
    rst_ni  = 1'b1;
    out_gnt = 1'b1;
    #1;
    chk("R_after", 72'(out_req), 72'(0));
    tick();
    chk("sb_empty", 72'(sb.size()), 72'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
